// File: rtl/wb_master.sv
// -----------------------------------------------------------------------------
// wb_master
// Wishbone classic single-transfer initiator for the PWM/timer register port.
// Accepts one read/write command at a time on a valid/ready command port, runs
// the bus cycle, and returns read data (or a timeout error) on a valid/ready
// response port.
//
// Ports
//   i_wb_clk, i_wb_rst        clock (rising edge), async active-high reset
//   i_cmd_valid/o_cmd_ready   command handshake; ready only while IDLE
//   i_cmd_we/adr/data         command: 1 = write, target address, write data
//   o_rsp_valid/i_rsp_ready   response handshake
//   o_rsp_data, o_rsp_err     read data (0 for writes/errors), timeout flag
//   o_wb_cyc/stb/we/adr/data  Wishbone initiator outputs
//   i_wb_data, i_wb_ack       Wishbone slave read data and acknowledge
// -----------------------------------------------------------------------------
module wb_master #(
    parameter int adr_width = 16,
    parameter int mem_width = 16,
    parameter int timeout   = 16,
    parameter int cnt_width = 8
) (
    input  logic                 i_wb_clk,
    input  logic                 i_wb_rst,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic                 i_cmd_we,
    input  logic [adr_width-1:0] i_cmd_adr,
    input  logic [mem_width-1:0] i_cmd_data,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [mem_width-1:0] o_rsp_data,
    output logic                 o_rsp_err,
    output logic                 o_wb_cyc,
    output logic                 o_wb_stb,
    output logic                 o_wb_we,
    output logic [adr_width-1:0] o_wb_adr,
    output logic [mem_width-1:0] o_wb_data,
    input  logic [mem_width-1:0] i_wb_data,
    input  logic                 i_wb_ack
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Last counter value before abort: cyc stays high exactly 'timeout' cycles.
    localparam logic [cnt_width-1:0] CNT_LAST = cnt_width'(timeout - 1);

    logic [1:0]           state;
    logic [cnt_width-1:0] cnt;

    // Decoded straight from the state register, so it reads 1 during reset.
    assign o_cmd_ready = (state == IDLE);

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_wb_we     <= 1'b0;
            o_wb_adr    <= '0;
            o_wb_data   <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        o_wb_we   <= i_cmd_we;
                        o_wb_adr  <= i_cmd_adr;
                        o_wb_data <= i_cmd_data;
                        o_wb_cyc  <= 1'b1;
                        o_wb_stb  <= 1'b1;
                        cnt       <= '0;
                        state     <= BUS;
                    end
                end
                BUS: begin
                    // Ack is checked first so it beats a simultaneous timeout.
                    if (i_wb_ack) begin
                        o_wb_cyc    <= 1'b0;
                        o_wb_stb    <= 1'b0;
                        o_wb_we     <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= 1'b0;
                        o_rsp_data  <= o_wb_we ? '0 : i_wb_data;
                        state       <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        o_wb_cyc    <= 1'b0;
                        o_wb_stb    <= 1'b0;
                        o_wb_we     <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= 1'b1;
                        o_rsp_data  <= '0;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master.sv
// -----------------------------------------------------------------------------
// tb_wb_master
// Scoreboard bench for wb_master. Stimulus pushes the expected bus cycle and
// response into queues; independent monitors pop and compare when the DUT ends
// a bus cycle or completes a response handshake. A small slave model acks a
// programmable number of cycles after cyc rises.
// -----------------------------------------------------------------------------
module tb_wb_master;

    typedef struct {
        logic [15:0] d;
        logic        e;
    } rsp_t;

    typedef struct {
        int          len;
        logic        we;
        logic [15:0] adr;
        logic [15:0] data;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [15:0] cmd_adr = '0;
    logic [15:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        wb_cyc, wb_stb, wb_we;
    logic [15:0] wb_adr, wb_dout;
    logic [15:0] wb_din = '0;
    logic        wb_ack = 1'b0;

    int checks = 0;
    int passes = 0;

    rsp_t rsp_q[$];
    bus_t bus_q[$];

    int slv_lat = 1;
    logic stray = 1'b0;
    logic rst_test = 1'b0;

    wb_master #(.adr_width(16), .mem_width(16), .timeout(16), .cnt_width(8)) dut (
        .i_wb_clk(clk), .i_wb_rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_we(cmd_we), .i_cmd_adr(cmd_adr), .i_cmd_data(cmd_data),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
        .o_wb_adr(wb_adr), .o_wb_data(wb_dout),
        .i_wb_data(wb_din), .i_wb_ack(wb_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s", name);
    endtask

    // Slave: ack when cyc has been high for slv_lat+1 post-edge samples.
    initial begin
        int wcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (wb_cyc) begin
                wcnt++;
                wb_ack = (wcnt == slv_lat + 1);
            end else begin
                wcnt = 0;
                wb_ack = stray;
            end
        end
    end

    // Response monitor: handshake happens at the next edge.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) fail_now("unexpected_rsp");
            else begin
                rsp_t r;
                r = rsp_q.pop_front();
                chk("rsp_data", {16'h0, rsp_data}, {16'h0, r.d});
                chk("rsp_err", {31'h0, rsp_err}, {31'h0, r.e});
            end
        end
    end

    // Bus monitor: measures cyc length and stability of the held fields.
    initial begin
        logic        prev = 1'b0;
        int          len = 0;
        logic        stable = 1'b1;
        logic        we0 = 1'b0;
        logic [15:0] adr0 = '0, dat0 = '0;
        forever begin
            @(negedge clk);
            if (wb_cyc) begin
                if (!prev) begin
                    len = 1; stable = 1'b1;
                    we0 = wb_we; adr0 = wb_adr; dat0 = wb_dout;
                end else begin
                    len++;
                    if (wb_we !== we0 || wb_adr !== adr0 || wb_dout !== dat0) stable = 1'b0;
                end
                if (wb_stb !== 1'b1) stable = 1'b0;
            end else if (prev && !rst_test) begin
                if (bus_q.size() == 0) fail_now("unexpected_cyc");
                else begin
                    bus_t b;
                    b = bus_q.pop_front();
                    chk("cyc_len", len, b.len);
                    chk("wb_we", {31'h0, we0}, {31'h0, b.we});
                    chk("wb_adr", {16'h0, adr0}, {16'h0, b.adr});
                    if (b.we) chk("wb_data", {16'h0, dat0}, {16'h0, b.data});
                    chk("bus_stable", {31'h0, stable}, 32'h1);
                end
            end
            prev = wb_cyc;
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) fail_now("cmd_ready_timeout");
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (rsp_q.size() != 0 || bus_q.size() != 0) fail_now("drain_timeout");
    endtask

    task automatic send(input logic we, input logic [15:0] adr, input logic [15:0] data,
                        input int lat, input logic [15:0] rdv,
                        input logic [15:0] exp_d, input logic exp_e, input int exp_len);
        bus_q.push_back('{exp_len, we, adr, data});
        rsp_q.push_back('{exp_d, exp_e});
        wait_ready();
        slv_lat = lat; wb_din = rdv;
        cmd_we = we; cmd_adr = adr; cmd_data = data; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_drain();
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        chk("rst_outs", {26'h0, wb_cyc, wb_stb, wb_we, rsp_valid, rsp_err, |{wb_adr, wb_dout, rsp_data}}, 32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Directed vectors: we, adr, data, ack latency, read value, exp data/err/len
        send(1'b1, 16'h0001, 16'h00FF, 1,    16'hDEAD, 16'h0000, 1'b0, 2);
        send(1'b0, 16'h0002, 16'h0000, 3,    16'h1234, 16'h1234, 1'b0, 4);
        send(1'b0, 16'h0005, 16'h0000, 1000, 16'hABCD, 16'h0000, 1'b1, 16);
        @(negedge clk);
        chk("ready_after_timeout", {31'h0, cmd_ready}, 32'h1);
        send(1'b1, 16'h0007, 16'h1111, 1000, 16'h2222, 16'h0000, 1'b1, 16);
        send(1'b0, 16'h0006, 16'h0000, 15,   16'h5A5A, 16'h5A5A, 1'b0, 16);
        send(1'b0, 16'h0008, 16'h0000, 0,    16'h0F0F, 16'h0F0F, 1'b0, 1);

        // Response backpressure with a second command held on the port
        bus_q.push_back('{2, 1'b0, 16'h0003, 16'h0000});
        rsp_q.push_back('{16'hBEEF, 1'b0});
        bus_q.push_back('{2, 1'b1, 16'h0004, 16'h0055});
        rsp_q.push_back('{16'h0000, 1'b0});
        wait_ready();
        rsp_ready = 1'b0; slv_lat = 1; wb_din = 16'hBEEF;
        cmd_we = 1'b0; cmd_adr = 16'h0003; cmd_data = 16'h0000; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_we = 1'b1; cmd_adr = 16'h0004; cmd_data = 16'h0055;
        begin
            int n = 0;
            @(negedge clk);
            while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            chk("bp_rsp_data", {16'h0, rsp_data}, 32'h0000BEEF);
            chk("bp_cmd_ready", {31'h0, cmd_ready}, 32'h0);
            chk("bp_no_cyc", {31'h0, wb_cyc}, 32'h0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("bp_ready_after_hs", {31'h0, cmd_ready}, 32'h1);
        chk("bp_cyc_after_hs", {31'h0, wb_cyc}, 32'h0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("bp_second_cyc", {31'h0, wb_cyc}, 32'h1);
        chk("bp_second_busy", {31'h0, cmd_ready}, 32'h0);
        wait_drain();

        // Stray ack while idle
        wait_ready();
        stray = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_no_cyc", {31'h0, wb_cyc}, 32'h0);
            chk("stray_no_rsp", {31'h0, rsp_valid}, 32'h0);
            chk("stray_ready", {31'h0, cmd_ready}, 32'h1);
        end
        stray = 1'b0;

        // Async reset in the middle of a bus cycle; no response expected
        wait_ready();
        rst_test = 1'b1;
        slv_lat = 1000;
        cmd_we = 1'b0; cmd_adr = 16'h0009; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_cyc", {31'h0, wb_cyc}, 32'h1);
        rst = 1'b1;
        #1;
        chk("arst_cyc", {31'h0, wb_cyc}, 32'h0);
        chk("arst_stb", {31'h0, wb_stb}, 32'h0);
        chk("arst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("arst_ready", {31'h0, cmd_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_ready", {31'h0, cmd_ready}, 32'h1);
        chk("post_rst_no_cyc", {31'h0, wb_cyc}, 32'h0);
        rst_test = 1'b0;

        // One more transfer after reset
        send(1'b0, 16'h000A, 16'h0000, 2, 16'hC0DE, 16'hC0DE, 1'b0, 3);
        repeat (3) @(negedge clk);
        chk("queues_empty", rsp_q.size() + bus_q.size(), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
